l1_trigger_scheduler: RTL and testbench

L1_TRIGGER_SCHEDULER -- requirements
Module: l1_trigger_scheduler

---
 rtl/l1_trig_pkg.sv | 16 +
 rtl/l1_trigger_scheduler_rr_arbiter.sv | 37 +++
 rtl/l1_trigger_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_l1_trigger_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_trig_pkg.sv
// l1_trig_pkg
//   Shared widths and the trigger record layout for the L1 trigger scheduler.
//   TS_BITS       : width of the free-running timestamp
//   BEAM_IDX_BITS : width of the beam index field of a record
//   trig_rec_t    : {beam[31:24], ts[23:0]}, the word presented on m_tdata
package l1_trig_pkg;

  localparam int TS_BITS       = 24;
  localparam int BEAM_IDX_BITS = 8;

  typedef struct packed {
    logic [BEAM_IDX_BITS-1:0] beam;
    logic [TS_BITS-1:0]       ts;
  } trig_rec_t;

endpackage

// File: rtl/l1_trigger_scheduler_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin selector. The search starts at
//   (last_i + 1) mod N and wraps upward, so the beam granted last has the
//   lowest priority on the next pick.
//   req_i  : request vector (one bit per beam)
//   last_i : index of the most recent grant
//   gnt_o  : one-hot grant (all zero when nothing is requested)
//   idx_o  : index of the granted beam (0 when nothing is requested)
//   any_o  : at least one request present
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin : sel
    int c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last_i) + i) % N;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/l1_trigger_scheduler.sv
// l1_trigger_scheduler
//   Turns per-beam L1 trigger levels into timestamped records on an
//   AXI-Stream-style output. Each beam has a holdoff timer, a one-deep
//   pending slot and a saturating fire counter; pending slots drain through a
//   round-robin arbiter into a single output register.
//   aclk, aresetn  : clock, asynchronous active-low reset
//   trig_i         : per-beam trigger level
//   mask_i         : per-beam ignore (1 = masked)
//   enable_i       : global fire enable (pending records still drain when low)
//   holdoff_i      : holdoff length loaded at each fire
//   count_clear_i  : synchronous clear of all counters (wins over increments)
//   m_tdata/m_tvalid/m_tready : record stream {beam[31:24], ts[23:0]}
//   fire_count_o   : per-beam fire counts, beam b at [b*CNT_BITS +: CNT_BITS]
//   drop_count_o   : fires lost because the beam's pending slot was occupied
module l1_trigger_scheduler
  import l1_trig_pkg::*;
#(
  parameter int NBEAMS       = 2,
  parameter int HOLDOFF_BITS = 8,
  parameter int CNT_BITS     = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NBEAMS-1:0]          trig_i,
  input  logic [NBEAMS-1:0]          mask_i,
  input  logic                       enable_i,
  input  logic [HOLDOFF_BITS-1:0]    holdoff_i,
  input  logic                       count_clear_i,
  output logic [31:0]                m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [NBEAMS*CNT_BITS-1:0] fire_count_o,
  output logic [CNT_BITS-1:0]        drop_count_o
);

  localparam int IDX_W  = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam int DROP_W = $clog2(NBEAMS + 1);
  localparam int SUM_W  = CNT_BITS + DROP_W;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NBEAMS - 1);

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] v,
                                                  input logic [DROP_W-1:0]   n);
    logic [SUM_W-1:0] s;
    s = SUM_W'(v) + SUM_W'(n);
    if (s[SUM_W-1:CNT_BITS] != '0) return '1;
    return s[CNT_BITS-1:0];
  endfunction

  logic [TS_BITS-1:0]      r_ts;
  logic [NBEAMS-1:0]       r_pending;
  logic [TS_BITS-1:0]      r_pend_ts  [NBEAMS];
  logic [HOLDOFF_BITS-1:0] r_holdoff  [NBEAMS];
  logic [CNT_BITS-1:0]     r_fire_cnt [NBEAMS];
  logic [CNT_BITS-1:0]     r_drop_cnt;
  logic [IDX_W-1:0]        r_last_grant;
  logic                    r_tvalid;
  trig_rec_t               r_rec;

  logic [NBEAMS-1:0]       w_fire;
  logic [NBEAMS-1:0]       w_gnt;
  logic [NBEAMS-1:0]       w_take;
  logic [NBEAMS-1:0]       w_drop;
  logic [IDX_W-1:0]        w_gnt_idx;
  logic                    w_any;
  logic                    w_load;
  logic [DROP_W-1:0]       w_drop_n;
  trig_rec_t               w_rec;

  // Stage p0: fire detection from trigger level, mask, enable and holdoff
  always_comb begin
    w_fire = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      w_fire[b] = trig_i[b] & ~mask_i[b] & enable_i & (r_holdoff[b] == '0);
    end
  end

  rr_arbiter #(
    .N     (NBEAMS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i  (r_pending),
    .last_i (r_last_grant),
    .gnt_o  (w_gnt),
    .idx_o  (w_gnt_idx),
    .any_o  (w_any)
  );

  // The output register only accepts a new record when it is empty or being
  // drained this cycle; a beam is only released from pending on that load.
  assign w_load = (~r_tvalid | m_tready) & w_any;
  assign w_take = w_gnt & {NBEAMS{w_load}};
  // A granted beam frees its slot in the same edge, so a fire there refills
  // the slot instead of being dropped.
  assign w_drop = w_fire & r_pending & ~w_take;

  always_comb begin
    w_drop_n = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      w_drop_n = w_drop_n + DROP_W'(w_drop[b]);
    end
  end

  always_comb begin
    w_rec.beam = BEAM_IDX_BITS'(w_gnt_idx);
    w_rec.ts   = r_pend_ts[w_gnt_idx];
  end

  // Stage p1: per-beam holdoff, pending slot and fire counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pending <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        r_pend_ts[b]  <= '0;
        r_holdoff[b]  <= '0;
        r_fire_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (w_fire[b]) begin
          r_holdoff[b] <= holdoff_i;
        end else if (r_holdoff[b] != '0) begin
          r_holdoff[b] <= r_holdoff[b] - HOLDOFF_BITS'(1);
        end

        if (w_fire[b] && !w_drop[b]) begin
          r_pending[b] <= 1'b1;
          r_pend_ts[b] <= r_ts;
        end else if (w_take[b]) begin
          r_pending[b] <= 1'b0;
        end

        if (count_clear_i) begin
          r_fire_cnt[b] <= '0;
        end else if (w_fire[b]) begin
          r_fire_cnt[b] <= sat_inc(r_fire_cnt[b]);
        end
      end
    end
  end

  // Stage p2: timestamp, drop counter and output record register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ts         <= '0;
      r_drop_cnt   <= '0;
      r_last_grant <= LAST_RST;
      r_tvalid     <= 1'b0;
      r_rec        <= '0;
    end else begin
      r_ts <= r_ts + TS_BITS'(1);

      if (count_clear_i) begin
        r_drop_cnt <= '0;
      end else if (w_drop_n != '0) begin
        r_drop_cnt <= sat_add(r_drop_cnt, w_drop_n);
      end

      if (w_load) begin
        r_rec        <= w_rec;
        r_tvalid     <= 1'b1;
        r_last_grant <= w_gnt_idx;
      end else if (m_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    fire_count_o = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      fire_count_o[b*CNT_BITS +: CNT_BITS] = r_fire_cnt[b];
    end
  end

  assign m_tdata      = r_rec;
  assign m_tvalid     = r_tvalid;
  assign drop_count_o = r_drop_cnt;

endmodule

// File: tb/tb_l1_trigger_scheduler.sv
module tb_l1_trigger_scheduler;

  localparam int NB   = 2;
  localparam int HB   = 8;
  localparam int CB   = 16;
  localparam int MAXC = (1 << CB) - 1;

  logic               aclk = 1'b0;
  logic               aresetn = 1'b0;
  logic [NB-1:0]      trig_i = '0;
  logic [NB-1:0]      mask_i = '0;
  logic               enable_i = 1'b0;
  logic [HB-1:0]      holdoff_i = '0;
  logic               count_clear_i = 1'b0;
  logic [31:0]        m_tdata;
  logic               m_tvalid;
  logic               m_tready = 1'b0;
  logic [NB*CB-1:0]   fire_count_o;
  logic [CB-1:0]      drop_count_o;

  l1_trigger_scheduler #(
    .NBEAMS       (NB),
    .HOLDOFF_BITS (HB),
    .CNT_BITS     (CB)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .trig_i        (trig_i),
    .mask_i        (mask_i),
    .enable_i      (enable_i),
    .holdoff_i     (holdoff_i),
    .count_clear_i (count_clear_i),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .fire_count_o  (fire_count_o),
    .drop_count_o  (drop_count_o)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: spec rules evaluated once per clock edge
  int          m_ts;
  int          m_hold [NB];
  bit          m_pend [NB];
  int          m_pts  [NB];
  int          m_fc   [NB];
  int          m_drop;
  int          m_lg;
  bit          m_vld;
  logic [31:0] m_data;
  logic [31:0] rec_q [$];

  function automatic void model_reset();
    m_ts = 0; m_drop = 0; m_lg = NB - 1; m_vld = 0; m_data = '0;
    for (int b = 0; b < NB; b++) begin
      m_hold[b] = 0; m_pend[b] = 0; m_pts[b] = 0; m_fc[b] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit any;
    bit found;
    bit gr [NB];
    bit f;
    int c;
    any = 0; found = 0;
    for (int b = 0; b < NB; b++) begin
      gr[b] = 0;
      if (m_pend[b]) any = 1;
    end
    if ((!m_vld || m_tready) && any) begin
      for (int k = 1; k <= NB; k++) begin
        c = (m_lg + k) % NB;
        if (!found && m_pend[c]) begin
          found = 1; gr[c] = 1; m_lg = c; m_vld = 1;
          m_data = {8'(c), 24'(m_pts[c])};
        end
      end
    end else if (m_tready) begin
      m_vld = 0;
    end
    for (int b = 0; b < NB; b++) begin
      f = trig_i[b] && !mask_i[b] && enable_i && (m_hold[b] == 0);
      if (f) begin
        if (m_fc[b] < MAXC) m_fc[b]++;
        if (m_pend[b] && !gr[b]) begin
          if (m_drop < MAXC) m_drop++;
        end else begin
          m_pend[b] = 1; m_pts[b] = m_ts;
        end
        m_hold[b] = int'(holdoff_i);
      end else begin
        if (gr[b]) m_pend[b] = 0;
        if (m_hold[b] > 0) m_hold[b]--;
      end
    end
    if (count_clear_i) begin
      m_drop = 0;
      for (int b = 0; b < NB; b++) m_fc[b] = 0;
    end
    m_ts = (m_ts + 1) % (1 << 24);
  endfunction

  function automatic logic [NB*CB-1:0] exp_fc();
    logic [NB*CB-1:0] v;
    v = '0;
    for (int b = 0; b < NB; b++) v[b*CB +: CB] = CB'(m_fc[b]);
    return v;
  endfunction

  task automatic step();
    if (m_tvalid && m_tready) rec_q.push_back(m_tdata);
    @(posedge aclk);
    model_edge();
    #1;
    check("tvalid", m_tvalid, m_vld);
    check("tdata", m_tdata, m_data);
    check("fire_count", fire_count_o, exp_fc());
    check("drop_count", drop_count_o, CB'(m_drop));
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    model_reset();
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tdata", m_tdata, 32'h0);
    check("rst_fire_count", fire_count_o, '0);
    check("rst_drop_count", drop_count_o, '0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rec_q.delete();
  endtask

  initial begin
    model_reset();

    // Initial reset
    do_reset();

    // Holdoff spacing: fires at 0, 5, 10 of an 11-cycle window
    enable_i = 1; m_tready = 1; holdoff_i = 4; trig_i = 2'b01;
    repeat (11) step();
    trig_i = 0;
    repeat (4) step();
    check("holdoff_fc0", fire_count_o[CB-1:0], 16'd3);
    check("holdoff_nrec", rec_q.size(), 3);
    if (rec_q.size() == 3) begin
      check("holdoff_rec0", rec_q[0], 32'h0000_0000);
      check("holdoff_rec1", rec_q[1], 32'h0000_0005);
      check("holdoff_rec2", rec_q[2], 32'h0000_000A);
    end

    // Simultaneous pulse, last_grant = 1 after reset: beam 0 first
    do_reset();
    enable_i = 1; m_tready = 1; holdoff_i = 0; trig_i = 2'b11;
    step();
    trig_i = 0;
    repeat (4) step();
    check("rr_nrec", rec_q.size(), 2);
    if (rec_q.size() == 2) begin
      check("rr_rec0", rec_q[0], 32'h0000_0000);
      check("rr_rec1", rec_q[1], 32'h0100_0000);
    end

    // Backpressure: three fires into a stalled output -> one drop
    do_reset();
    enable_i = 1; m_tready = 0; holdoff_i = 0; trig_i = 2'b01;
    repeat (3) step();
    trig_i = 0;
    repeat (17) step();
    check("bp_hold_valid", m_tvalid, 1'b1);
    check("bp_hold_data", m_tdata, 32'h0000_0000);
    check("bp_drop", drop_count_o, 16'd1);
    check("bp_fc0", fire_count_o[CB-1:0], 16'd3);
    m_tready = 1;
    repeat (4) step();
    check("bp_nrec", rec_q.size(), 2);
    if (rec_q.size() == 2) begin
      check("bp_rec0", rec_q[0], 32'h0000_0000);
      check("bp_rec1", rec_q[1], 32'h0000_0001);
    end

    // Mask and enable block beam 1; pending record drains with enable low
    do_reset();
    enable_i = 1; m_tready = 1; mask_i = 2'b10; trig_i = 2'b10;
    step();
    trig_i = 0;
    repeat (3) step();
    enable_i = 0; mask_i = 0; trig_i = 2'b10;
    step();
    trig_i = 0;
    repeat (3) step();
    check("blk_fc1", fire_count_o[CB +: CB], 16'd0);
    check("blk_nrec", rec_q.size(), 0);
    m_tready = 0; enable_i = 1; trig_i = 2'b01;
    step();
    trig_i = 0; enable_i = 0;
    repeat (3) step();
    m_tready = 1;
    repeat (3) step();
    check("drain_nrec", rec_q.size(), 1);
    if (rec_q.size() == 1) check("drain_rec", rec_q[0], 32'h0000_0008);

    // Counter saturation, then clear together with a fire
    do_reset();
    enable_i = 1; m_tready = 1; holdoff_i = 0; trig_i = 2'b01;
    repeat (MAXC + 3) step();
    check("sat_fc0", fire_count_o[CB-1:0], 16'hFFFF);
    count_clear_i = 1;
    step();
    count_clear_i = 0; trig_i = 0;
    check("clr_fc0", fire_count_o[CB-1:0], 16'd0);
    repeat (3) step();

    // Reset while a record is held; timestamp restarts
    do_reset();
    enable_i = 1; m_tready = 0; trig_i = 2'b01;
    step();
    trig_i = 0;
    repeat (3) step();
    check("mid_valid", m_tvalid, 1'b1);
    do_reset();
    step();
    trig_i = 2'b10;
    step();
    trig_i = 0; m_tready = 1;
    repeat (4) step();
    check("post_nrec", rec_q.size(), 1);
    if (rec_q.size() == 1) check("post_rec", rec_q[0], 32'h0100_0001);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      trig_i        = NB'($urandom);
      mask_i        = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
      enable_i      = ($urandom_range(0, 7) != 0);
      holdoff_i     = HB'($urandom_range(0, 6));
      m_tready      = ($urandom_range(0, 2) != 0);
      count_clear_i = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
